// File: rtl/lsu_multi_outstanding_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
//   req/gnt            : beat request and grant; addr/we/be/wdata valid while req is high
//   addr/we/be/wdata   : word-aligned address, write flag, byte enables, lane-aligned write data
//   rvalid/rdata/err   : one in-order response beat per granted beat
interface lsu_multi_outstanding_if;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/lsu_multi_outstanding.sv
// Pipelined load/store unit between execute and the data-memory bus.
// Accepts one op per handshake, splits misaligned accesses into two bus beats, tracks up to
// MAX_OUTSTANDING granted beats in an in-order pending FIFO and returns results (load data,
// store completions, bus errors) on a single writeback port.
//   clk_i, rst_ni       : clock, asynchronous active-low reset
//   flush_i             : drop the queued op and suppress writeback of every in-flight beat
//   req_*               : op handshake and fields from execute
//   data_bus            : data-memory bus (master side)
//   wb_*                : writeback valid, transaction ID, load data, error
module lsu_multi_outstanding #(
  parameter int unsigned ADDR_BITS       = 5,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        flush_i,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic                        req_we_i,
  input  logic [1:0]                  req_size_i,
  input  logic                        req_signed_i,
  input  logic [ADDR_BITS-1:0]        req_trans_id_i,
  input  logic [31:0]                 req_addr_i,
  input  logic [31:0]                 req_wdata_i,
  lsu_multi_outstanding_if.master     data_bus,
  output logic                        wb_vld_o,
  output logic [ADDR_BITS-1:0]        wb_trans_id_o,
  output logic [31:0]                 wb_data_o,
  output logic                        wb_err_o
);

  localparam int unsigned PtrW = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StBeat1, StBeat2} state_e;

  typedef struct packed {
    logic [ADDR_BITS-1:0] trans_id;
    logic                 we;
    logic [1:0]           size;
    logic                 sext;
    logic [1:0]           offset;
    logic                 split_first;
    logic                 last;
  } entry_t;

  function automatic logic is_split(input logic [1:0] size, input logic [1:0] off);
    return (size[1] && off != 2'd0) || (size == 2'b01 && off == 2'd3);
  endfunction

  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  state_e state_q, state_d;

  logic                 op_we_q, op_sext_q;
  logic [1:0]           op_size_q;
  logic [ADDR_BITS-1:0] op_id_q;
  logic [31:0]          op_addr_q, op_wdata_q;

  entry_t                     fifo_q [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] kill_q, kill_d;
  logic [PtrW-1:0]            wptr_q, rptr_q;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic [31:0]                hold_q;
  logic                       err_q;

  logic        busy, in_beat2, op_split, beat_last, bus_req;
  logic        gnt_fire, final_gnt, accept, push, pop;
  logic [1:0]  op_off;
  logic [7:0]  be_wide;
  logic [63:0] wdata_wide;
  entry_t      new_entry, head;
  logic        head_kill;
  logic [63:0] head_word;
  logic [31:0] lo, load_val;

  // Issue side
  assign op_off    = op_addr_q[1:0];
  assign busy      = (state_q != StIdle);
  assign in_beat2  = (state_q == StBeat2);
  assign op_split  = is_split(op_size_q, op_off);
  assign beat_last = in_beat2 | ~op_split;
  // A pop in the same cycle does not free a slot, keeping gnt->req free of rvalid paths.
  assign bus_req   = busy & (cnt_q < CntW'(MAX_OUTSTANDING));
  assign gnt_fire  = bus_req & data_bus.gnt;
  assign final_gnt = gnt_fire & beat_last;

  assign req_ready_o = ~flush_i & (~busy | final_gnt);
  assign accept      = req_valid_i & req_ready_o;

  // Beat 2 lanes are the bits shifted past lane 3 by the beat 1 alignment.
  assign be_wide    = {4'b0000, size_mask(op_size_q)} << op_off;
  assign wdata_wide = {32'h0, op_wdata_q} << {op_off, 3'b000};

  assign data_bus.req   = bus_req;
  assign data_bus.we    = busy & op_we_q;
  assign data_bus.addr  = busy ? ({op_addr_q[31:2], 2'b00} + (in_beat2 ? 32'd4 : 32'd0)) : 32'h0;
  assign data_bus.be    = busy ? (in_beat2 ? be_wide[7:4] : be_wide[3:0]) : 4'h0;
  assign data_bus.wdata = busy ? (in_beat2 ? wdata_wide[63:32] : wdata_wide[31:0]) : 32'h0;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StBeat1;
      StBeat1: if (gnt_fire) state_d = op_split ? StBeat2 : (accept ? StBeat1 : StIdle);
      StBeat2: if (gnt_fire) state_d = accept ? StBeat1 : StIdle;
      default: state_d = StIdle;
    endcase
    if (flush_i) state_d = StIdle;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      op_we_q    <= 1'b0;
      op_sext_q  <= 1'b0;
      op_size_q  <= 2'b00;
      op_id_q    <= '0;
      op_addr_q  <= 32'h0;
      op_wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (flush_i) begin
        op_we_q    <= 1'b0;
        op_sext_q  <= 1'b0;
        op_size_q  <= 2'b00;
        op_id_q    <= '0;
        op_addr_q  <= 32'h0;
        op_wdata_q <= 32'h0;
      end else if (accept) begin
        op_we_q    <= req_we_i;
        op_sext_q  <= req_signed_i;
        op_size_q  <= req_size_i;
        op_id_q    <= req_trans_id_i;
        op_addr_q  <= req_addr_i;
        op_wdata_q <= req_wdata_i;
      end
    end
  end

  // Pending FIFO
  assign push = gnt_fire;
  assign pop  = data_bus.rvalid & (cnt_q != '0);

  always_comb begin
    new_entry             = '0;
    new_entry.trans_id    = op_id_q;
    new_entry.we          = op_we_q;
    new_entry.size        = op_size_q;
    new_entry.sext        = op_sext_q;
    new_entry.offset      = op_off;
    new_entry.split_first = ~in_beat2 & op_split;
    new_entry.last        = beat_last;
  end

  always_comb begin
    kill_d = kill_q;
    if (flush_i) kill_d = '1;
    // A beat granted in the flush cycle is already dead.
    if (push) kill_d[wptr_q] = flush_i;
    cnt_d = cnt_q + CntW'(push) - CntW'(pop);
  end

  assign head      = fifo_q[rptr_q];
  assign head_kill = kill_q[rptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) fifo_q[i] <= '0;
      kill_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      hold_q <= 32'h0;
      err_q  <= 1'b0;
    end else begin
      kill_q <= kill_d;
      cnt_q  <= cnt_d;
      if (push) begin
        fifo_q[wptr_q] <= new_entry;
        wptr_q         <= wptr_q + PtrW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + PtrW'(1);
        if (head_kill || head.last) begin
          hold_q <= 32'h0;
          err_q  <= 1'b0;
        end else begin
          hold_q <= data_bus.rdata;
          err_q  <= data_bus.err;
        end
      end
    end
  end

  // Writeback
  assign head_word = is_split(head.size, head.offset) ? {data_bus.rdata, hold_q}
                                                      : {32'h0, data_bus.rdata};
  assign lo = 32'(head_word >> {head.offset, 3'b000});

  always_comb begin
    case (head.size)
      2'b00:   load_val = {{24{head.sext & lo[7]}}, lo[7:0]};
      2'b01:   load_val = {{16{head.sext & lo[15]}}, lo[15:0]};
      default: load_val = lo;
    endcase
  end

  assign wb_vld_o      = pop & head.last & ~head_kill;
  assign wb_err_o      = wb_vld_o & (err_q | data_bus.err);
  assign wb_trans_id_o = wb_vld_o ? head.trans_id : '0;
  assign wb_data_o     = (wb_vld_o & ~head.we & ~wb_err_o) ? load_val : 32'h0;

endmodule

// File: tb/tb_lsu_multi_outstanding.sv
// Directed bench for lsu_multi_outstanding: bus responder with programmable response delay,
// negedge monitor logging grants and writebacks, hand-computed expectations per scenario.
module tb_lsu_multi_outstanding;
  localparam int unsigned AB = 5;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
  } gnt_t;

  typedef struct {
    int          cyc;
    logic [31:0] id;
    logic [31:0] data;
    logic        err;
  } wb_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic          req_signed = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic [AB-1:0] req_id = '0;
  logic [31:0]   req_addr = 32'h0;
  logic [31:0]   req_wdata = 32'h0;
  logic          req_ready, wb_vld, wb_err;
  logic [AB-1:0] wb_id;
  logic [31:0]   wb_data;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          rsp_delay = 1;
  int          acc_cyc = 0;
  int          req_cycles = 0;
  int          outst = 0;
  gnt_t        gnt_log[$];
  wb_t         wb_log[$];
  int          pend_q[$];
  int          rv_cycles[$];
  logic [31:0] rsp_data_q[$];
  logic        rsp_err_q[$];

  lsu_multi_outstanding_if bus ();

  lsu_multi_outstanding #(
    .ADDR_BITS       (AB),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .flush_i        (flush),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_we_i       (req_we),
    .req_size_i     (req_size),
    .req_signed_i   (req_signed),
    .req_trans_id_i (req_id),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .data_bus       (bus),
    .wb_vld_o       (wb_vld),
    .wb_trans_id_o  (wb_id),
    .wb_data_o      (wb_data),
    .wb_err_o       (wb_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Monitor: sampled mid-cycle, i.e. the values the next rising edge acts on.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (bus.rvalid) begin
        check("rvalid_has_pending_beat", 32'(outst != 0), 32'd1);
        if (outst > 0) outst--;
        rv_cycles.push_back(cyc);
      end
      if (bus.req) req_cycles++;
      if (bus.req && bus.gnt) begin
        gnt_log.push_back('{cyc: cyc, addr: bus.addr, wdata: bus.wdata, be: bus.be, we: bus.we});
        pend_q.push_back(cyc);
        outst++;
      end
      if (req_valid && req_ready) acc_cyc = cyc;
      if (wb_vld) wb_log.push_back('{cyc: cyc, id: 32'(wb_id), data: wb_data, err: wb_err});
    end
  end

  // Responder: one in-order response per granted beat, rsp_delay cycles after its grant.
  initial begin
    bus.rvalid = 1'b0;
    bus.rdata  = 32'h0;
    bus.err    = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (pend_q.size() > 0 && cyc >= pend_q[0] + rsp_delay) begin
        void'(pend_q.pop_front());
        bus.rvalid = 1'b1;
        bus.rdata  = (rsp_data_q.size() > 0) ? rsp_data_q.pop_front() : 32'h0;
        bus.err    = (rsp_err_q.size() > 0) ? rsp_err_q.pop_front() : 1'b0;
      end else begin
        bus.rvalid = 1'b0;
        bus.rdata  = 32'h0;
        bus.err    = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    gnt_log.delete();
    wb_log.delete();
    rv_cycles.delete();
    req_cycles = 0;
  endtask

  task automatic rsp(input logic [31:0] d, input logic e);
    rsp_data_q.push_back(d);
    rsp_err_q.push_back(e);
  endtask

  task automatic send(input logic we, input logic [1:0] size, input logic sext,
                      input logic [AB-1:0] id, input logic [31:0] addr, input logic [31:0] wdata);
    int n = 0;
    req_valid = 1'b1;
    req_we = we;
    req_size = size;
    req_signed = sext;
    req_id = id;
    req_addr = addr;
    req_wdata = wdata;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int n_wb);
    int n = 0;
    while ((wb_log.size() < n_wb || pend_q.size() != 0) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) check("wait_timeout", 32'd0, 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_b [6];
    int          early;
    exp_b = '{32'h55, 32'h66, 32'h77, 32'hFFFF_FF88, 32'h55, 32'h66};
    bus.gnt = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_data_req", 32'(bus.req), 32'd0);
    check("rst_addr", bus.addr, 32'h0);
    check("rst_be", 32'(bus.be), 32'h0);
    check("rst_wdata", bus.wdata, 32'h0);
    check("rst_we", 32'(bus.we), 32'd0);
    check("rst_wb_vld", 32'(wb_vld), 32'd0);
    check("rst_wb_id", 32'(wb_id), 32'd0);
    check("rst_wb_data", wb_data, 32'h0);
    check("rst_wb_err", 32'(wb_err), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.gnt = 1'b1;
    @(posedge clk);
    #1;

    // Aligned LW
    clear_logs();
    rsp_delay = 1;
    rsp(32'h8000_00FF, 1'b0);
    send(1'b0, 2'b10, 1'b0, 5'd3, 32'h100, 32'h0);
    wait_done(1);
    check("lw_ngnt", gnt_log.size(), 1);
    check("lw_addr", gnt_log[0].addr, 32'h100);
    check("lw_be", 32'(gnt_log[0].be), 32'hF);
    check("lw_we", 32'(gnt_log[0].we), 32'd0);
    check("lw_req_latency", gnt_log[0].cyc - acc_cyc, 32'd1);
    check("lw_nwb", wb_log.size(), 1);
    check("lw_wb_data", wb_log[0].data, 32'h8000_00FF);
    check("lw_wb_err", 32'(wb_log[0].err), 32'd0);
    check("lw_wb_id", wb_log[0].id, 32'd3);
    check("lw_wb_latency", wb_log[0].cyc - gnt_log[0].cyc, 32'd1);

    // Split signed LH at 0x103
    clear_logs();
    rsp(32'hAB00_0000, 1'b0);
    rsp(32'h0000_00CD, 1'b0);
    send(1'b0, 2'b01, 1'b1, 5'd5, 32'h103, 32'h0);
    wait_done(1);
    check("lh_ngnt", gnt_log.size(), 2);
    check("lh_addr1", gnt_log[0].addr, 32'h100);
    check("lh_be1", 32'(gnt_log[0].be), 32'h8);
    check("lh_addr2", gnt_log[1].addr, 32'h104);
    check("lh_be2", 32'(gnt_log[1].be), 32'h1);
    check("lh_nwb", wb_log.size(), 1);
    check("lh_wb_data", wb_log[0].data, 32'hFFFF_CDAB);
    check("lh_wb_id", wb_log[0].id, 32'd5);

    // Split SW at 0x201
    clear_logs();
    rsp(32'h0, 1'b0);
    rsp(32'h0, 1'b0);
    send(1'b1, 2'b10, 1'b0, 5'd7, 32'h201, 32'h1122_3344);
    wait_done(1);
    check("sw_ngnt", gnt_log.size(), 2);
    check("sw_addr1", gnt_log[0].addr, 32'h200);
    check("sw_be1", 32'(gnt_log[0].be), 32'hE);
    check("sw_wdata1", gnt_log[0].wdata, 32'h2233_4400);
    check("sw_we1", 32'(gnt_log[0].we), 32'd1);
    check("sw_addr2", gnt_log[1].addr, 32'h204);
    check("sw_be2", 32'(gnt_log[1].be), 32'h1);
    check("sw_wdata2", gnt_log[1].wdata, 32'h0000_0011);
    check("sw_nwb", wb_log.size(), 1);
    check("sw_wb_data", wb_log[0].data, 32'h0);
    check("sw_wb_id", wb_log[0].id, 32'd7);
    check("sw_wb_on_last_rvalid", wb_log[0].cyc - gnt_log[1].cyc, 32'd1);

    // Six back-to-back signed LB, slow responses: FIFO fills at 4
    clear_logs();
    rsp_delay = 8;
    for (int i = 0; i < 6; i++) rsp(32'h8877_6655, 1'b0);
    for (int i = 0; i < 6; i++) send(1'b0, 2'b00, 1'b1, AB'(i + 1), 32'h10 + 32'(i), 32'h0);
    wait_done(6);
    early = 0;
    foreach (gnt_log[i]) if (gnt_log[i].cyc <= rv_cycles[0]) early++;
    check("b2b_ngnt", gnt_log.size(), 6);
    check("b2b_gnts_before_pop", early, 4);
    check("b2b_gnt5_after_pop", gnt_log[4].cyc - rv_cycles[0], 32'd1);
    check("b2b_req_cycles", req_cycles, 6);
    check("b2b_nwb", wb_log.size(), 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("b2b_wb%0d_id", i), wb_log[i].id, 32'(i + 1));
      check($sformatf("b2b_wb%0d_data", i), wb_log[i].data, exp_b[i]);
    end

    // Flush after beat 1 of a split LW, then LBU at 0x3
    clear_logs();
    rsp_delay = 3;
    rsp(32'hDEAD_BEEF, 1'b0);
    rsp(32'hCC00_0000, 1'b0);
    send(1'b0, 2'b10, 1'b0, 5'd9, 32'h2, 32'h0);
    @(posedge clk);
    #1;
    flush = 1'b1;
    bus.gnt = 1'b0;
    @(negedge clk);
    check("fl_ready_in_flush", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.gnt = 1'b1;
    send(1'b0, 2'b00, 1'b0, 5'd10, 32'h3, 32'h0);
    wait_done(1);
    check("fl_ngnt", gnt_log.size(), 2);
    check("fl_be1", 32'(gnt_log[0].be), 32'hC);
    check("fl_lbu_addr", gnt_log[1].addr, 32'h0);
    check("fl_lbu_be", 32'(gnt_log[1].be), 32'h8);
    check("fl_nwb", wb_log.size(), 1);
    check("fl_wb_id", wb_log[0].id, 32'd10);
    check("fl_wb_data", wb_log[0].data, 32'h0000_00CC);
    check("fl_wb_err", 32'(wb_log[0].err), 32'd0);

    // Split LW with error on beat 1 only, then a clean LW
    clear_logs();
    rsp_delay = 1;
    rsp(32'h1234_5678, 1'b1);
    rsp(32'h9ABC_DEF0, 1'b0);
    rsp(32'h0102_0304, 1'b0);
    send(1'b0, 2'b10, 1'b0, 5'd11, 32'h105, 32'h0);
    wait_done(1);
    send(1'b0, 2'b10, 1'b0, 5'd12, 32'h100, 32'h0);
    wait_done(2);
    check("err_nwb", wb_log.size(), 2);
    check("err_wb_id", wb_log[0].id, 32'd11);
    check("err_wb_err", 32'(wb_log[0].err), 32'd1);
    check("err_wb_data", wb_log[0].data, 32'h0);
    check("err_next_id", wb_log[1].id, 32'd12);
    check("err_next_err", 32'(wb_log[1].err), 32'd0);
    check("err_next_data", wb_log[1].data, 32'h0102_0304);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
